spi_reg_master: RTL and testbench

- SPI initiator for the team's SPI register slave (16-bit frame: command byte, then data byte; 4-bit address).
- Lets an on-chip controller or test harness issue single register writes and reads over the external SPI pins.
- Drives cs_n, sclk and mosi; samples miso.
- Runs on the system clock; SCLK is generated by a programmable divider.

---
 rtl/spi_reg_master.sv | 143 ++++++++++++++
 tb/tb_spi_reg_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_master
// Purpose  : SPI mode-0 initiator issuing single 16-bit register read/write
//            frames (command byte, data byte) to the SPI register slave.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_master #(
    parameter int ADDR_W  = 4,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rdata,
    output logic              spi_cs_n,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;
    localparam logic [1:0] c_st_gap   = 2'd3;
    localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_div;
    logic        r_high;
    logic [3:0]  r_bit;
    logic [15:0] r_shift;
    logic [7:0]  r_rx;
    logic        r_rw;
    logic        r_cs_n;
    logic        r_sclk;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_rdata;

    logic [6:0]  w_cmd_addr;
    logic [15:0] w_frame;

    assign w_cmd_addr = 7'(addr);
    assign w_frame    = {rw, w_cmd_addr, (rw ? wdata : 8'h00)};

    // mosi is the shift register MSB; after 16 shifts the register is all
    // zeros, which holds mosi low through HOLD and GAP.
    assign spi_mosi = r_shift[15];
    assign spi_cs_n = r_cs_n;
    assign spi_clk  = r_sclk;
    assign busy     = r_busy;
    assign done     = r_done;
    assign rdata    = r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_div   <= 8'd0;
            r_high  <= 1'b0;
            r_bit   <= 4'd0;
            r_shift <= 16'h0000;
            r_rx    <= 8'h00;
            r_rw    <= 1'b0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state <= c_st_shift;
                        r_shift <= w_frame;
                        r_rw    <= rw;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_div   <= 8'd0;
                        r_high  <= 1'b0;
                        r_bit   <= 4'd0;
                    end
                end
                c_st_shift: begin
                    if (r_div == c_div_last) begin
                        r_div <= 8'd0;
                        if (!r_high) begin
                            r_high <= 1'b1;
                            r_sclk <= 1'b1;
                        end else begin
                            // Sample at the tail of the high phase so the
                            // slave's synchronized response has settled.
                            r_high  <= 1'b0;
                            r_sclk  <= 1'b0;
                            r_rx    <= {r_rx[6:0], spi_miso};
                            r_shift <= {r_shift[14:0], 1'b0};
                            if (r_bit == 4'd15) begin
                                r_state <= c_st_hold;
                            end else begin
                                r_bit <= r_bit + 4'd1;
                            end
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                c_st_hold: begin
                    if (r_div == c_div_last) begin
                        r_div   <= 8'd0;
                        r_state <= c_st_gap;
                        r_cs_n  <= 1'b1;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                c_st_gap: begin
                    if (r_div == c_div_last) begin
                        r_div   <= 8'd0;
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (!r_rw) begin
                            r_rdata <= r_rx;
                        end
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_reg_master
// Purpose  : Scoreboard bench for spi_reg_master (CLK_DIV=4 unit plus a
//            CLK_DIV=3 unit looped back through a synchronized slave model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_master;

    localparam int D4 = 4;
    localparam int D3 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- CLK_DIV=4 unit ----------------
    logic       start4 = 1'b0, rw4 = 1'b0;
    logic [3:0] addr4 = 4'h0;
    logic [7:0] wdata4 = 8'h00;
    logic       busy4, done4, cs4, sclk4, mosi4;
    logic [7:0] rdata4;
    logic       miso4 = 1'b1;

    spi_reg_master #(.ADDR_W(4), .CLK_DIV(D4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .rw(rw4), .addr(addr4), .wdata(wdata4),
        .busy(busy4), .done(done4), .rdata(rdata4),
        .spi_cs_n(cs4), .spi_clk(sclk4), .spi_mosi(mosi4), .spi_miso(miso4)
    );

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  rdata;
        int          t1;
        bit          chk_gap;
    } exp_t;

    exp_t q4[$];
    logic [7:0] pat4 = 8'h5A;
    logic [7:0] exp_rd4 = 8'h00;

    // Monitor for the CLK_DIV=4 unit; also plays the slave's miso role.
    logic        p_cs = 1'b1, p_sclk = 1'b0;
    int          edges = 0, busy_cnt = 0, fall_cyc = 0, hi_run = 0, last_gap = 0, viol = 0;
    logic [15:0] word = 16'h0;
    exp_t        e4;

    always @(negedge clk) begin
        if (cs4 && sclk4) viol++;
        if (!cs4 && p_cs) begin
            fall_cyc = cyc;
            edges    = 0;
            word     = 16'h0;
            busy_cnt = 0;
            last_gap = hi_run;
            miso4    = 1'b1;
        end
        if (cs4) hi_run++;
        else     hi_run = 0;
        if (busy4) busy_cnt++;
        if (sclk4 && !p_sclk) begin
            edges++;
            word = {word[14:0], mosi4};
        end
        if (!sclk4 && p_sclk)
            miso4 = (edges >= 8 && edges < 16) ? pat4[15-edges] : 1'b1;
        if (done4) begin
            if (q4.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL done4_unexpected: got done=1 expected no frame pending (cycle %0d)", cyc);
            end else begin
                e4 = q4.pop_front();
                chk("mosi_frame", 32'(word), 32'(e4.frame));
                chk("sclk_rises", 32'(edges), 32'd16);
                chk("rdata", 32'(rdata4), 32'(e4.rdata));
                chk("cs_fall_cycle", 32'(fall_cyc), 32'(e4.t1));
                chk("done_latency", 32'(cyc - fall_cyc), 32'(34*D4));
                chk("busy_cycles", 32'(busy_cnt), 32'(34*D4));
                // GAP cycles plus the idle done cycle separate frames.
                if (e4.chk_gap) chk("cs_gap", 32'(last_gap), 32'(D4 + 1));
            end
        end
        p_cs   = cs4;
        p_sclk = sclk4;
    end

    task automatic issue4(input bit r, input logic [3:0] a, input logic [7:0] d);
        exp_t e;
        start4 = 1'b1; rw4 = r; addr4 = a; wdata4 = d;
        tick();
        e.frame   = {r, 3'b000, a, (r ? d : 8'h00)};
        if (!r) exp_rd4 = pat4;
        e.rdata   = exp_rd4;
        e.t1      = cyc;
        e.chk_gap = 1'b0;
        q4.push_back(e);
        start4 = 1'b0; rw4 = ~r; addr4 = ~a; wdata4 = ~d;
    endtask

    task automatic drain4(input int max);
        int k = 0;
        while (q4.size() != 0 && k < max) begin tick(); k++; end
        chk("q4_drained", 32'(q4.size()), 32'd0);
    endtask

    // ---------------- CLK_DIV=3 unit with synchronized slave model ----------------
    logic       start3 = 1'b0, rw3 = 1'b0;
    logic [3:0] addr3 = 4'h0;
    logic [7:0] wdata3 = 8'h00;
    logic       busy3, done3, cs3, sclk3, mosi3;
    logic [7:0] rdata3;
    logic       miso3 = 1'b0;

    spi_reg_master #(.ADDR_W(4), .CLK_DIV(D3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .rw(rw3), .addr(addr3), .wdata(wdata3),
        .busy(busy3), .done(done3), .rdata(rdata3),
        .spi_cs_n(cs3), .spi_clk(sclk3), .spi_mosi(mosi3), .spi_miso(miso3)
    );

    logic [2:0]  s_sclk = 3'b000;
    logic [1:0]  s_cs = 2'b11, s_mosi = 2'b00;
    logic [15:0] s_rx = 16'h0;
    int          s_cnt = 0;
    logic [7:0]  s_tx = 8'h00;
    logic [7:0]  s_reg_in = 8'hC3;
    logic        s_wr = 1'b0;
    logic [3:0]  s_waddr = 4'h0;
    logic [7:0]  s_wdata = 8'h00;
    logic        s_rise, s_fall;
    assign s_rise = s_sclk[1] & ~s_sclk[2];
    assign s_fall = ~s_sclk[1] & s_sclk[2];

    always @(posedge clk) begin
        s_sclk <= {s_sclk[1:0], sclk3};
        s_cs   <= {s_cs[0], cs3};
        s_mosi <= {s_mosi[0], mosi3};
        s_wr   <= 1'b0;
        if (rst || s_cs[1]) begin
            s_cnt <= 0;
            miso3 <= 1'b0;
        end else begin
            if (s_rise) begin
                s_rx  <= {s_rx[14:0], s_mosi[1]};
                s_cnt <= s_cnt + 1;
                if (s_cnt == 15 && s_rx[14]) begin
                    s_wr    <= 1'b1;
                    s_waddr <= s_rx[10:7];
                    s_wdata <= {s_rx[6:0], s_mosi[1]};
                end
            end
            if (s_fall && s_cnt == 8) begin
                miso3 <= s_reg_in[7];
                s_tx  <= {s_reg_in[6:0], 1'b0};
            end else if (s_fall && s_cnt > 8 && s_cnt < 16) begin
                miso3 <= s_tx[7];
                s_tx  <= {s_tx[6:0], 1'b0};
            end
        end
    end

    logic [7:0]  q3[$];
    logic [11:0] qw[$];
    logic [7:0]  e3;
    logic [11:0] ew;

    always @(negedge clk) begin
        if (done3) begin
            if (q3.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL done3_unexpected: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e3 = q3.pop_front();
                chk("loop_rdata", 32'(rdata3), 32'(e3));
            end
        end
        if (s_wr) begin
            if (qw.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL slave_wr_unexpected: got addr %0h data %0h expected none", s_waddr, s_wdata);
            end else begin
                ew = qw.pop_front();
                chk("slave_wr", 32'({s_waddr, s_wdata}), 32'(ew));
            end
        end
    end

    task automatic issue3(input bit r, input logic [3:0] a, input logic [7:0] d);
        start3 = 1'b1; rw3 = r; addr3 = a; wdata3 = d;
        tick();
        start3 = 1'b0; wdata3 = 8'h00;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t1;
        exp_t e;
        tick(3);
        chk("rst_cs_n", 32'(cs4), 32'd1);
        chk("rst_sclk", 32'(sclk4), 32'd0);
        chk("rst_mosi", 32'(mosi4), 32'd0);
        chk("rst_busy", 32'(busy4), 32'd0);
        chk("rst_done", 32'(done4), 32'd0);
        chk("rst_rdata", 32'(rdata4), 32'd0);
        rst = 1'b0;
        tick(2);

        // Write 0x83 / 0xA5, then read of address 0xC returning 0x5A.
        issue4(1'b1, 4'h3, 8'hA5);
        drain4(400);
        tick(3);
        pat4 = 8'h5A;
        issue4(1'b0, 4'hC, 8'h77);
        drain4(400);
        tick(3);

        // Start while busy is ignored.
        issue4(1'b1, 4'h2, 8'h11);
        tick(49);
        start4 = 1'b1; rw4 = 1'b1; addr4 = 4'h7; wdata4 = 8'hEE;
        tick();
        start4 = 1'b0;
        drain4(400);
        tick(200);

        // Back-to-back with start held high.
        start4 = 1'b1; rw4 = 1'b1; addr4 = 4'h5; wdata4 = 8'h3C;
        tick();
        t1 = cyc;
        e.frame = 16'h853C; e.rdata = exp_rd4; e.t1 = t1; e.chk_gap = 1'b0;
        q4.push_back(e);
        addr4 = 4'h6; wdata4 = 8'hC5;
        e.frame = 16'h86C5; e.rdata = exp_rd4; e.t1 = t1 + 34*D4 + 1; e.chk_gap = 1'b1;
        q4.push_back(e);
        tick(34*D4 + 1);
        start4 = 1'b0;
        drain4(400);
        tick(3);

        // Reset after 5 bits of a frame: abort without done.
        pat4 = 8'h99;
        issue4(1'b0, 4'h1, 8'hFF);
        void'(q4.pop_back());
        tick(5*2*D4 - 1);
        rst = 1'b1;
        tick();
        chk("abort_cs_n", 32'(cs4), 32'd1);
        chk("abort_sclk", 32'(sclk4), 32'd0);
        chk("abort_mosi", 32'(mosi4), 32'd0);
        chk("abort_busy", 32'(busy4), 32'd0);
        chk("abort_rdata", 32'(rdata4), 32'd0);
        rst = 1'b0;
        exp_rd4 = 8'h00;
        tick(300);
        issue4(1'b1, 4'hA, 8'h5C);
        drain4(400);

        // Loopback through the synchronized slave model at minimum divider.
        qw.push_back({4'h9, 8'h3C});
        q3.push_back(8'h00);
        issue3(1'b1, 4'h9, 8'h3C);
        tick(40*D3);
        q3.push_back(8'hC3);
        issue3(1'b0, 4'h2, 8'h00);
        tick(40*D3);
        chk("q3_drained", 32'(q3.size()), 32'd0);
        chk("qw_drained", 32'(qw.size()), 32'd0);
        chk("sclk_while_cs_high", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
